// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared state encoding, default-configuration widths and clamp helper
// for the matrix multiply engine.
package mm_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_A, FETCH_B, DRAIN, WRITE, DONE} state_t;

  // Widths of the default configuration (M=8, N=4, O=8, LANES=2, IW=4, WW=8).
  localparam int G      = 8 / 2;
  localparam int ROW_W  = $clog2(8);
  localparam int GRP_W  = $clog2(G);
  localparam int PROD_W = 4 + 8;
  localparam int SUM_W  = PROD_W + $clog2(4);

  // Clamp an extended sum into the ow-bit signed or unsigned range.
  function automatic logic [63:0] mm_saturate(input logic [63:0] v, input int ow, input logic sgn);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = sgn ? (64'sd1 <<< (ow - 1)) - 64'sd1 : (64'sd1 <<< ow) - 64'sd1;
    lo = sgn ? -(64'sd1 <<< (ow - 1)) : 64'sd0;
    if ($signed(v) > hi) return hi;
    if ($signed(v) < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mm_dot_lane.sv
// rtl/mm_dot_lane.sv - one dot-product lane: registered products, registered sum,
// then wrap or clamp to the output width.
module mm_dot_lane
  import mm_pkg::*;
#(
  parameter int N        = 4,
  parameter int IW       = 4,
  parameter int WW       = 8,
  parameter int OW       = 16,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en1,
  input  logic            en2,
  input  logic [N*IW-1:0] a_row,
  input  logic [N*WW-1:0] b_row,
  output logic [OW-1:0]   result
);

  localparam int PW = IW + WW;
  localparam int SW = PW + $clog2(N);

  logic [PW-1:0] prod_nx [N];
  logic [PW-1:0] prod_q  [N];
  logic [SW-1:0] sum_nx;
  logic [SW-1:0] sum_q;
  logic [63:0]   wide;

  // Operands are extended to the product width so one multiplier serves both modes.
  always_comb begin
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    for (int k = 0; k < N; k++) begin
      ea = {{(PW-IW){(SIGNED != 0) & a_row[k*IW+IW-1]}}, a_row[k*IW +: IW]};
      eb = {{(PW-WW){(SIGNED != 0) & b_row[k*WW+WW-1]}}, b_row[k*WW +: WW]};
      prod_nx[k] = ea * eb;
    end
  end

  always_comb begin
    sum_nx = '0;
    for (int k = 0; k < N; k++)
      sum_nx = sum_nx + {{(SW-PW){(SIGNED != 0) & prod_q[k][PW-1]}}, prod_q[k]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) prod_q[k] <= '0;
      sum_q <= '0;
    end else begin
      if (en1)
        for (int k = 0; k < N; k++) prod_q[k] <= prod_nx[k];
      if (en2) sum_q <= sum_nx;
    end
  end

  always_comb begin
    wide   = {{(64-SW){(SIGNED != 0) & sum_q[SW-1]}}, sum_q};
    result = (SATURATE != 0) ? OW'(mm_saturate(wide, OW, SIGNED != 0)) : wide[OW-1:0];
  end

endmodule

// File: rtl/matrix_mult_engine.sv
// rtl/matrix_mult_engine.sv - row-at-a-time C = A * B engine with LANES parallel
// dot-product lanes and a valid/ready row output.
module matrix_mult_engine
  import mm_pkg::*;
#(
  parameter int BATCH_SIZE      = 8,
  parameter int INPUT_FEATURES  = 4,
  parameter int OUTPUT_FEATURES = 8,
  parameter int LANES           = 2,
  parameter int INPUT_WIDTH     = 4,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int OUTPUT_WIDTH    = 16,
  parameter int SIGNED          = 0,
  parameter int SATURATE        = 0,
  localparam int NG = OUTPUT_FEATURES / LANES,
  localparam int RW = $clog2(BATCH_SIZE),
  localparam int GW = $clog2(NG)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  output logic                                           busy,
  output logic                                           done,
  output logic [RW-1:0]                                  in_addr,
  output logic                                           in_rd_en,
  input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]          in_data,
  output logic [GW-1:0]                                  w_addr,
  output logic                                           w_rd_en,
  input  logic [LANES*INPUT_FEATURES*WEIGHT_WIDTH-1:0]   w_data,
  output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0]        out_data,
  output logic [RW-1:0]                                  out_addr,
  output logic                                           out_valid,
  input  logic                                           out_ready
);

  localparam int N  = INPUT_FEATURES;
  localparam int WW = WEIGHT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int GB = LANES * OW;

  if ((OUTPUT_FEATURES % LANES) != 0 || BATCH_SIZE < 2 || NG < 2) begin : g_bad_cfg
    $error("matrix_mult_engine: O must be a multiple of LANES and M, G must be >= 2");
  end

  state_t                state, state_nx;
  logic [RW-1:0]         row;
  logic [GW-1:0]         grp;
  logic [N*INPUT_WIDTH-1:0] a_reg;
  logic                  v1, v2, v3;
  logic [GW-1:0]         g1, g2, g3;
  logic [(NG-1)*GB-1:0]  row_buf;
  logic [GB-1:0]         lane_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row     <= '0;
      grp     <= '0;
      a_reg   <= '0;
      {v1, v2, v3} <= '0;
      {g1, g2, g3} <= '0;
      row_buf <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) row <= '0;
      else if (state == WRITE && out_ready && row != RW'(BATCH_SIZE - 1)) row <= row + RW'(1);
      if (state == LOAD_A) grp <= '0;
      else if (state == FETCH_B && grp != GW'(NG - 1)) grp <= grp + GW'(1);
      if (state == FETCH_B && grp == '0) a_reg <= in_data;
      v1 <= w_rd_en;
      g1 <= grp;
      v2 <= v1;
      g2 <= g1;
      v3 <= v2;
      g3 <= g2;
      // The last group is presented straight from the lane registers, so only earlier groups are buffered.
      if (v3 && g3 != GW'(NG - 1)) row_buf[int'(g3)*GB +: GB] <= lane_res;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    in_rd_en  = 1'b0;
    w_rd_en   = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = LOAD_A;
      LOAD_A: begin
        busy     = 1'b1;
        in_rd_en = 1'b1;
        state_nx = FETCH_B;
      end
      FETCH_B: begin
        busy    = 1'b1;
        w_rd_en = 1'b1;
        if (grp == GW'(NG - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (v2 && g2 == GW'(NG - 1)) state_nx = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = (row == RW'(BATCH_SIZE - 1)) ? DONE : LOAD_A;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_addr  = row;
  assign out_addr = row;
  assign w_addr   = grp;
  assign out_data = {lane_res, row_buf};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mm_dot_lane #(
      .N(N), .IW(INPUT_WIDTH), .WW(WW), .OW(OW), .SIGNED(SIGNED), .SATURATE(SATURATE)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en1    (v1),
      .en2    (v2),
      .a_row  (a_reg),
      .b_row  (w_data[l*N*WW +: N*WW]),
      .result (lane_res[l*OW +: OW])
    );
  end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// tb/tb_matrix_mult_engine.sv - directed bench: identity, all-max, saturation,
// backpressure, start-while-busy and mid-run reset.
module tb_matrix_mult_engine;
  import mm_pkg::*;

  localparam logic [PROD_W-1:0] MAX_PROD = 12'd3825;   // 15 * 255
  localparam logic [SUM_W-1:0]  MAX_SUM  = 14'd15300;  // 4 * 3825 = 0x3BC4

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic busy, done, in_rd_en, w_rd_en, out_valid;
  logic [ROW_W-1:0] in_addr, out_addr;
  logic [GRP_W-1:0] w_addr;
  logic [15:0]  in_data;
  logic [63:0]  w_data;
  logic [127:0] out_data;

  logic start2 = 1'b0, out_ready2 = 1'b1;
  logic busy2, done2, in_rd_en2, w_rd_en2, out_valid2;
  logic [2:0]  in_addr2, out_addr2;
  logic [1:0]  w_addr2;
  logic [15:0] in_data2 = '0;
  logic [63:0] w_data2 = '0;
  logic [63:0] out_data2;

  logic [15:0] amem [8];
  logic [63:0] wmem [G];

  int n_tests = 0;
  int n_fail  = 0;

  matrix_mult_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_rd_en(in_rd_en), .in_data(in_data),
    .w_addr(w_addr), .w_rd_en(w_rd_en), .w_data(w_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready)
  );

  matrix_mult_engine #(.OUTPUT_WIDTH(8), .SIGNED(1), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .in_addr(in_addr2), .in_rd_en(in_rd_en2), .in_data(in_data2),
    .w_addr(w_addr2), .w_rd_en(w_rd_en2), .w_data(w_data2),
    .out_data(out_data2), .out_addr(out_addr2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  always @(posedge clk) begin
    if (in_rd_en) in_data <= amem[in_addr];
    if (w_rd_en)  w_data  <= wmem[w_addr];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_row(input int mode, input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 8; c++)
      v[c*16 +: 16] = (mode == 0) ? ((c < 4) ? 16'(r) : 16'd0) : 16'(MAX_SUM);
    return v;
  endfunction

  task automatic set_identity();
    for (int r = 0; r < 8; r++) amem[r] = {4{4'(r)}};
    for (int g = 0; g < G; g++) begin
      wmem[g] = '0;
      for (int l = 0; l < 2; l++)
        if (g*2 + l < 4) wmem[g][l*32 + (g*2+l)*8 +: 8] = 8'd1;
    end
  endtask

  task automatic set_allmax();
    for (int r = 0; r < 8; r++) amem[r] = 16'hFFFF;
    for (int g = 0; g < G; g++) wmem[g] = '1;
  endtask

  // One full run; intervals are counted from the first cycle after the start-sampling edge.
  task automatic do_run(input int mode, input int bp_row, input int hold, input int pulse_at, input int exp_done);
    int n, rows, held;
    bit fin;
    logic [127:0] snap;
    @(negedge clk);
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n = 1; rows = 0; held = 0; fin = 0; snap = '0;
    while (!fin && n < 400) begin
      start = (n == pulse_at);
      if (n == 1) check("busy_after_start", busy, 1'b1);
      if (out_valid) begin
        check("no_strobe_in_write", {in_rd_en, w_rd_en}, 2'b00);
        if (out_addr == bp_row && held < hold) begin
          if (held == 0) snap = out_data;
          else begin
            check("bp_data_stable", out_data, snap);
            check("bp_addr_stable", out_addr, 3'(bp_row));
          end
          out_ready = 1'b0;
          held++;
        end else begin
          check("row_addr", out_addr, rows);
          check("row_data", out_data, exp_row(mode, rows));
          out_ready = 1'b1;
          rows++;
        end
      end else out_ready = 1'b1;
      if (done) begin
        fin = 1;
        check("done_cycle", n, exp_done);
        check("rows_written", rows, 8);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!fin) check("done_timeout", 1'b0, 1'b1);
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic run_sat(input string tag, input logic [63:0] exp);
    int n;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_valid"}, out_valid2, 1'b1);
    check(tag, out_data2, exp);
    n = 0;
    while (!done2 && n < 200) begin @(negedge clk); n++; end
    check({tag, "_done"}, done2, 1'b1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, in_rd_en, w_rd_en, out_valid}, 5'b0);
    check("rst_addr", {in_addr, w_addr, out_addr}, 8'h00);
    check("rst_data", out_data, 128'h0);
    check("rst_data_sat", out_data2, 64'h0);
    rst_n = 1'b1;

    set_identity();
    do_run(0, -1, 0, -1, 65);
    do_run(0, 3, 5, -1, 70);
    do_run(0, -1, 0, 10, 65);
    do_run(0, -1, 0, -1, 65);

    set_allmax();
    do_run(1, -1, 0, -1, 65);

    // Abort during FETCH_B of row 2, then restart from scratch.
    set_identity();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 19) begin @(negedge clk); n++; end
    check("abort_in_fetch_row2", {w_rd_en, out_addr}, {1'b1, 3'd2});
    #1 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {busy, done, in_rd_en, w_rd_en, out_valid}, 5'b0);
    check("abort_addr", {in_addr, w_addr, out_addr}, 8'h00);
    check("abort_data", out_data, 128'h0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    do_run(0, -1, 0, -1, 65);

    in_data2 = {4{4'd7}};
    w_data2  = {8{8'd127}};
    run_sat("sat_pos", {8{8'h7F}});
    in_data2 = {4{4'h8}};
    run_sat("sat_neg", {8{8'h80}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
